// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
// Bundles the two requester handshakes and the data-memory port of
// dmem_arbiter.
//   slave  : arbiter view (requests and memory response in, done/data/strobes out)
//   master : environment view (requesters plus memory model)
// Requester side : Req{0,1}Read, Req{0,1}Write, Req{0,1}Addr, Req{0,1}WData,
//                  Done0, Done1, RData, Err, Busy
// Memory side    : MemRead_wire, MemWrite_wire, MemAddress_wire,
//                  MemWriteData_wire, MemValid_wire, Datamem_wire
interface dmem_arbiter_if;
  logic        Req0Read;
  logic        Req0Write;
  logic [31:0] Req0Addr;
  logic [31:0] Req0WData;
  logic        Req1Read;
  logic        Req1Write;
  logic [31:0] Req1Addr;
  logic [31:0] Req1WData;
  logic        Done0;
  logic        Done1;
  logic [31:0] RData;
  logic        Err;
  logic        Busy;
  logic        MemRead_wire;
  logic        MemWrite_wire;
  logic [31:0] MemAddress_wire;
  logic [31:0] MemWriteData_wire;
  logic        MemValid_wire;
  logic [31:0] Datamem_wire;

  modport slave (
    input  Req0Read, Req0Write, Req0Addr, Req0WData,
    input  Req1Read, Req1Write, Req1Addr, Req1WData,
    input  MemValid_wire, Datamem_wire,
    output Done0, Done1, RData, Err, Busy,
    output MemRead_wire, MemWrite_wire, MemAddress_wire, MemWriteData_wire
  );

  modport master (
    output Req0Read, Req0Write, Req0Addr, Req0WData,
    output Req1Read, Req1Write, Req1Addr, Req1WData,
    output MemValid_wire, Datamem_wire,
    input  Done0, Done1, RData, Err, Busy,
    input  MemRead_wire, MemWrite_wire, MemAddress_wire, MemWriteData_wire
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-requester round-robin arbiter and sequencer for the single data-memory
// port. Requests are granted in IDLE, the latched op/address/data are driven
// to memory in BUSY until MemValid_wire, and a one-cycle Done pulse (with read
// data in RData) is issued in DONE.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : dmem_arbiter_if.slave (requester handshakes + memory port)
// Parameter:
//   TIMEOUT_CYCLES : BUSY-cycle limit, only used when DMEM_ARB_TIMEOUT_EN is
//                    defined; otherwise BUSY waits indefinitely and Err is 0.
module dmem_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic        last_gnt_q, last_gnt_d;
  logic        gnt_id_q, gnt_id_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;

  logic        req0_any, req1_any;
  logic        gnt;

  assign req0_any = bus.Req0Read | bus.Req0Write;
  assign req1_any = bus.Req1Read | bus.Req1Write;

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    gnt_id_d    = gnt_id_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    gnt         = 1'b0;
`ifdef DMEM_ARB_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0_any || req1_any) begin
          // On a tie the requester not served last wins; otherwise whoever asks.
          gnt         = (req0_any && req1_any) ? ~last_gnt_q : req1_any;
          gnt_id_d    = gnt;
          last_gnt_d  = gnt;
          addr_d      = gnt ? bus.Req1Addr  : bus.Req0Addr;
          wdata_d     = gnt ? bus.Req1WData : bus.Req0WData;
          // Read together with write counts as a write.
          mem_write_d = gnt ? bus.Req1Write : bus.Req0Write;
          mem_read_d  = ~(gnt ? bus.Req1Write : bus.Req0Write);
          state_d     = BUSY;
`ifdef DMEM_ARB_TIMEOUT_EN
          tmo_cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        if (bus.MemValid_wire) begin
          // mem_read_q is still set here, so it tells us whether to capture.
          if (mem_read_q) rdata_d = bus.Datamem_wire;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          done0_d     = ~gnt_id_q;
          done1_d     = gnt_id_q;
          state_d     = DONE;
`ifdef DMEM_ARB_TIMEOUT_EN
          err_d       = 1'b0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          // Last allowed BUSY cycle ended without a response: abort.
          rdata_d     = '0;
          err_d       = 1'b1;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          done0_d     = ~gnt_id_q;
          done1_d     = gnt_id_q;
          state_d     = DONE;
        end else begin
          tmo_cnt_d   = tmo_cnt_q + 1'b1;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef DMEM_ARB_TIMEOUT_EN
        err_d   = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_gnt_q  <= 1'b1;
      gnt_id_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
`ifdef DMEM_ARB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      gnt_id_q    <= gnt_id_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
`ifdef DMEM_ARB_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign bus.MemRead_wire      = mem_read_q;
  assign bus.MemWrite_wire     = mem_write_q;
  assign bus.MemAddress_wire   = addr_q;
  assign bus.MemWriteData_wire = wdata_q;
  assign bus.RData             = rdata_q;
  assign bus.Done0             = done0_q;
  assign bus.Done1             = done1_q;
  assign bus.Busy              = (state_q != IDLE);
`ifdef DMEM_ARB_TIMEOUT_EN
  assign bus.Err               = err_q;
`else
  assign bus.Err               = 1'b0;
`endif

endmodule
